beep_sequencer: RTL
===================

// Module: beep_sequencer
// PURPOSE
//  Audio feedback stage downstream of the ball-motion block (jumping): consumes beep_flag[1:0] and over_flag
//  and drives a square-wave buzzer pin with short note sequences (bounce, miss, game over).
//  Instantiated in ballplayer_top on the 12 MHz system clock, beside the LED/segment status outputs.
// PARAMETERS
//  CLK_HZ   12_000_000  input clock frequency; all timing derives from it
//  NOTE_MS  80          tone duration per note, ms  -> NOTE_CYC = CLK_HZ/1000*NOTE_MS
//  GAP_MS   20          silence between notes, ms   -> GAP_CYC  = CLK_HZ/1000*GAP_MS
//  F_HI     2000        high note, Hz -> HALF_HI  = CLK_HZ/(2*F_HI)
//  F_MID    1000        mid note, Hz  -> HALF_MID = CLK_HZ/(2*F_MID)
//  F_LO     500         low note, Hz  -> HALF_LO  = CLK_HZ/(2*F_LO)
// PORTS
//  clk        in   1  system clock (12 MHz)
//  rst_n      in   1  asynchronous active-low reset
//  beep_flag  in   2  event code from jumping: 00 none, 01 bounce, 10 miss, 11 treated as 01
//  over_flag  in   1  game-over level from jumping
//  mute       in   1  1 = force beep low (sequence still runs)
//  beep       out  1  buzzer square wave
//  busy       out  1  1 while a sequence plays
// BEHAVIOUR
//  - One clock, clk; reset asynchronous active-low on rst_n. All inputs are synchronous to clk.
//  - Reset: beep=0, busy=0, state IDLE, counters 0, prev_flag=2'b11, prev_over=1 (held inputs do not retrigger on release).
//  - Triggers (edge only): T_OVER = over_flag & ~prev_over; T_MISS = beep_flag==10 & prev_flag==00;
//    T_BOUNCE = beep_flag in {01,11} & prev_flag==00. prev_* registered every cycle.
//  - Priority OVER(3) > MISS(2) > BOUNCE(1). Same-cycle triggers: highest wins, others dropped.
//  - Sequences: BOUNCE = HI; MISS = MID,LO; OVER = HI,MID,LO (OVER compiled per BEEP_OVER_JINGLE_EN).
//  - FSM: IDLE -> TONE on accepted trigger; TONE -> GAP after NOTE_CYC cycles if notes remain, else IDLE;
//    GAP -> TONE after GAP_CYC cycles with next note. No trailing gap after last note.
//  - Latency: trigger sampled at edge N -> busy=1 and beep=1 from edge N+1 (first half-period high).
//  - TONE: half-period counter reloads HALF_x; beep toggles each time it expires (HALF_x cycles high, HALF_x low).
//    NOTE_CYC counts total tone cycles; at expiry beep forced 0 on the same edge.
//  - GAP/IDLE: beep=0. busy=1 in TONE and GAP, 0 in IDLE; busy drops on the edge beep is forced 0 for the last note.
//  - Pre-emption: trigger of strictly higher priority than the active sequence restarts at its note 1 next edge
//    (beep=1, counters reloaded). Equal or lower priority triggers while busy are ignored (not queued).
//  - mute=1: beep output 0 combinationally gated; FSM/busy unaffected.
//  - Widths: counters sized by $clog2 of max(NOTE_CYC,GAP_CYC,HALF_LO)+1; no wrap, all counts terminate.
//  - Reset mid-sequence: outputs go 0 immediately (async), sequence discarded.
// CONFIGURATION
//  BEEP_OVER_JINGLE_EN defined: over_flag rising edge plays the 3-note OVER sequence with top priority.
//  Not defined: over_flag ignored entirely (no T_OVER, priority set is MISS > BOUNCE); port remains.
// TESTING  (CLK_HZ=12000, NOTE_MS=4 ->48 cyc, GAP_MS=1 ->12 cyc, HALF_HI=3, HALF_MID=6, HALF_LO=12)
//  1. beep_flag 00->01 one cycle -> next edge busy=1, beep 3 high/3 low x8 (48 cyc), then beep=0, busy=0.
//  2. beep_flag 00->10 -> 48 cyc @half 6, 12 cyc beep=0, 48 cyc @half 12; busy high exactly 108 cyc.
//  3. (EN) bounce playing, over_flag 0->1 at cycle 20 -> next edge restart HI note; busy 168 cyc from restart.
//  4. MISS playing, beep_flag 00->01 mid-note -> ignored; waveform identical to test 2.
//  5. mute=1 + bounce trigger -> beep constantly 0, busy high 48 cyc.
//  6. rst_n low at cycle 10 of a note with beep_flag held 01 -> beep=0,busy=0 immediately; after release
//     no retrigger until beep_flag returns 00 then 01. Without EN: over_flag 0->1 -> busy stays 0.

Source files
------------

// File: rtl/beep_sequencer.sv
// Buzzer note sequencer (bounce/miss/game-over); optional OVER jingle under BEEP_OVER_JINGLE_EN.
// Latency: trigger edge -> beep/busy one clock later; no backpressure, and lower/equal triggers while busy are dropped.
module beep_sequencer #(
    parameter int CLK_HZ  = 12_000_000,
    parameter int NOTE_MS = 80,
    parameter int GAP_MS  = 20,
    parameter int F_HI    = 2000,
    parameter int F_MID   = 1000,
    parameter int F_LO    = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] beep_flag,
    input  logic       over_flag,
    input  logic       mute,
    output logic       beep,
    output logic       busy
);
    localparam int NOTE_CYC = CLK_HZ / 1000 * NOTE_MS;
    localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
    localparam int HALF_HI  = CLK_HZ / (2 * F_HI);
    localparam int HALF_MID = CLK_HZ / (2 * F_MID);
    localparam int HALF_LO  = CLK_HZ / (2 * F_LO);
    localparam int MAX_A    = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
    localparam int MAX_CYC  = (MAX_A > HALF_LO) ? MAX_A : HALF_LO;
    localparam int CW       = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] NOTE_LD = CW'(NOTE_CYC - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] HI_LD   = CW'(HALF_HI - 1);
    localparam logic [CW-1:0] MID_LD  = CW'(HALF_MID - 1);
    localparam logic [CW-1:0] LO_LD   = CW'(HALF_LO - 1);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    state_t        state, state_nxt;
    logic [1:0]    seq, seq_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [CW-1:0] dur_cnt, dur_nxt;
    logic [CW-1:0] half_cnt, half_nxt;
    logic          beep_q, beep_nxt;
    logic [1:0]    prev_flag;
    logic          prev_over;
    logic          t_over, t_miss, t_bounce, accept;
    logic [1:0]    trig_pri, cur_pri;

    // Sequence code doubles as priority: 1 bounce (HI), 2 miss (MID,LO), 3 over (HI,MID,LO).
    function automatic logic [CW-1:0] half_ld(input logic [1:0] s, input logic [1:0] i);
        case (s)
            2'd2:    half_ld = (i == 2'd0) ? MID_LD : LO_LD;
            2'd3:    half_ld = (i == 2'd0) ? HI_LD : ((i == 2'd1) ? MID_LD : LO_LD);
            default: half_ld = HI_LD;
        endcase
    endfunction

`ifdef BEEP_OVER_JINGLE_EN
    assign t_over = over_flag & ~prev_over;
`else
    logic unused_over;
    assign t_over      = 1'b0;
    assign unused_over = over_flag ^ prev_over;
`endif
    assign t_miss   = (beep_flag == 2'b10) && (prev_flag == 2'b00);
    assign t_bounce = beep_flag[0] && (prev_flag == 2'b00);
    assign trig_pri = t_over ? 2'd3 : (t_miss ? 2'd2 : (t_bounce ? 2'd1 : 2'd0));
    assign cur_pri  = (state == IDLE) ? 2'd0 : seq;
    assign accept   = trig_pri > cur_pri;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            seq       <= 2'd0;
            idx       <= 2'd0;
            dur_cnt   <= '0;
            half_cnt  <= '0;
            beep_q    <= 1'b0;
            prev_flag <= 2'b11;
            prev_over <= 1'b1;
        end else begin
            state     <= state_nxt;
            seq       <= seq_nxt;
            idx       <= idx_nxt;
            dur_cnt   <= dur_nxt;
            half_cnt  <= half_nxt;
            beep_q    <= beep_nxt;
            prev_flag <= beep_flag;
            prev_over <= over_flag;
        end
    end

    always_comb begin
        state_nxt = state;
        seq_nxt   = seq;
        idx_nxt   = idx;
        dur_nxt   = dur_cnt;
        half_nxt  = half_cnt;
        beep_nxt  = beep_q;
        if (accept) begin
            // Covers both start from idle and pre-emption by a higher-priority event.
            state_nxt = TONE;
            seq_nxt   = trig_pri;
            idx_nxt   = 2'd0;
            dur_nxt   = NOTE_LD;
            half_nxt  = half_ld(trig_pri, 2'd0);
            beep_nxt  = 1'b1;
        end else begin
            case (state)
                TONE: begin
                    if (dur_cnt == '0) begin
                        beep_nxt = 1'b0;
                        half_nxt = '0;
                        if (idx == seq - 2'd1) begin
                            state_nxt = IDLE;
                            dur_nxt   = '0;
                        end else begin
                            state_nxt = GAP;
                            dur_nxt   = GAP_LD;
                        end
                    end else begin
                        dur_nxt = dur_cnt - 1'b1;
                        if (half_cnt == '0) begin
                            beep_nxt = ~beep_q;
                            half_nxt = half_ld(seq, idx);
                        end else begin
                            half_nxt = half_cnt - 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (dur_cnt == '0) begin
                        state_nxt = TONE;
                        idx_nxt   = idx + 2'd1;
                        dur_nxt   = NOTE_LD;
                        half_nxt  = half_ld(seq, idx + 2'd1);
                        beep_nxt  = 1'b1;
                    end else begin
                        dur_nxt = dur_cnt - 1'b1;
                    end
                end
                default: begin
                    beep_nxt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        beep = beep_q & ~mute;
        busy = (state != IDLE);
    end
endmodule
